// File: rtl/deal_pkg.sv
// Shared types, deck constants and the card-to-value rule for the deal datapath.
package deal_pkg;

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned RANKS     = 13;

  localparam logic [5:0] DECK_SIZE_W = 6'(DECK_SIZE);
  localparam logic [5:0] LAST_CARD_W = 6'(DECK_SIZE - 1);
  localparam logic [5:0] RANKS_W     = 6'(RANKS);

  typedef enum logic [1:0] {
    ST_SHUFFLE = 2'd0,
    ST_READY   = 2'd1,
    ST_FETCH   = 2'd2,
    ST_ISSUE   = 2'd3
  } state_e;

  // Blackjack value of a card index: ace = 1, 2..9 face value, ten and courts = 10.
  // Indices beyond the deck map to 0 so a corrupted read is easy to spot.
  function automatic logic [3:0] card_value(input logic [5:0] card);
    logic [5:0] rank;
    rank = card % RANKS_W;
    if (card > LAST_CARD_W) begin
      card_value = 4'd0;
    end else if (rank < 6'd9) begin
      card_value = rank[3:0] + 4'd1;
    end else begin
      card_value = 4'd10;
    end
  endfunction

endpackage

// File: rtl/card_value_lut.sv
// Combinational card index to blackjack value lookup; also used by hand-sum logic.
module card_value_lut
  import deal_pkg::*;
(
  input  logic [5:0] card_i,
  output logic [3:0] value_o
);

  // Pure table lookup through the shared package rule.
  always_comb begin
    value_o = card_value(card_i);
  end

endmodule

// File: rtl/deal_scheduler.sv
// Deck read sequencer: triggers shuffles, runs the opening deal and serves
// player/dealer card requests, one card every three cycles.
module deal_scheduler
  import deal_pkg::*;
#(
  parameter int unsigned RESHUFFLE_AT = 15
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       shuffle_req_o,
  input  logic       shuffle_done_i,
  output logic [5:0] deck_idx_o,
  input  logic [5:0] deck_card_i,
  input  logic       round_start_i,
  input  logic       round_end_i,
  input  logic       hit_req_i,
  input  logic       dealer_req_i,
  output logic       hit_ack_o,
  output logic       dealer_ack_o,
  output logic       card_valid_o,
  output logic [5:0] card_out_o,
  output logic [3:0] card_value_o,
  output logic       card_to_dealer_o,
  output logic [5:0] cards_left_o,
  output logic       busy_o
);

  localparam logic [5:0] RESHUFFLE_LVL = 6'(RESHUFFLE_AT);

  state_e     state_q, state_d;
  logic [5:0] ptr_q, ptr_d;
  logic [5:0] left_q, left_d;
  logic [2:0] init_cnt_q, init_cnt_d;
  logic       end_pend_q, end_pend_d;
  logic       in_round_q, in_round_d;
  logic       pend_q, pend_d;          // a card target survives an empty-deck shuffle
  logic       tgt_dealer_q, tgt_dealer_d;
  logic       tgt_init_q, tgt_init_d;  // current card belongs to the opening deal
  logic       shuffle_req_q, shuffle_req_d;
  logic       card_valid_q, card_valid_d;
  logic       hit_ack_q, hit_ack_d;
  logic       dealer_ack_q, dealer_ack_d;
  logic       to_dealer_q, to_dealer_d;
  logic       busy_q, busy_d;
  logic [3:0] lut_value_s;

  card_value_lut u_lut (
    .card_i  (card_out_o),
    .value_o (lut_value_s)
  );

  // Next-state, pointer bookkeeping and next output values.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    left_d       = left_q;
    init_cnt_d   = init_cnt_q;
    end_pend_d   = end_pend_q;
    in_round_d   = in_round_q;
    pend_d       = pend_q;
    tgt_dealer_d = tgt_dealer_q;
    tgt_init_d   = tgt_init_q;
    card_valid_d = 1'b0;
    hit_ack_d    = 1'b0;
    dealer_ack_d = 1'b0;
    to_dealer_d  = 1'b0;

    case (state_q)
      ST_SHUFFLE: begin
        if (shuffle_done_i) begin
          ptr_d   = 6'd0;
          left_d  = DECK_SIZE_W;
          pend_d  = 1'b0;
          state_d = pend_q ? ST_FETCH : ST_READY;
        end else begin
          state_d = ST_SHUFFLE;
        end
      end
      ST_READY: begin
        if (end_pend_q) begin
          // A closed round also abandons any unfinished opening cards.
          end_pend_d = 1'b0;
          in_round_d = 1'b0;
          init_cnt_d = 3'd0;
          state_d    = (left_q < RESHUFFLE_LVL) ? ST_SHUFFLE : ST_READY;
        end else if (round_start_i && !in_round_q) begin
          in_round_d   = 1'b1;
          init_cnt_d   = 3'd4;
          tgt_init_d   = 1'b1;
          tgt_dealer_d = 1'b0;
          state_d      = ST_FETCH;
        end else if (init_cnt_q != 3'd0) begin
          // Odd counts (3, 1) are the dealer's opening cards.
          tgt_init_d   = 1'b1;
          tgt_dealer_d = init_cnt_q[0];
          state_d      = ST_FETCH;
        end else if (hit_req_i && in_round_q) begin
          tgt_init_d   = 1'b0;
          tgt_dealer_d = 1'b0;
          state_d      = ST_FETCH;
        end else if (dealer_req_i && in_round_q) begin
          tgt_init_d   = 1'b0;
          tgt_dealer_d = 1'b1;
          state_d      = ST_FETCH;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_FETCH: begin
        if (left_q == 6'd0) begin
          pend_d  = 1'b1;
          state_d = ST_SHUFFLE;
        end else begin
          card_valid_d = 1'b1;
          hit_ack_d    = !tgt_init_q && !tgt_dealer_q;
          dealer_ack_d = !tgt_init_q && tgt_dealer_q;
          to_dealer_d  = tgt_dealer_q;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Wrap keeps the pointer inside the deck even after the last card.
        ptr_d  = (ptr_q == LAST_CARD_W) ? 6'd0 : ptr_q + 6'd1;
        left_d = left_q - 6'd1;
        if (tgt_init_q) begin
          init_cnt_d = init_cnt_q - 3'd1;
        end else begin
          init_cnt_d = init_cnt_q;
        end
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_SHUFFLE;
      end
    endcase

    if (round_end_i) begin
      end_pend_d = 1'b1;
    end else begin
      end_pend_d = end_pend_d;
    end

    shuffle_req_d = (state_d == ST_SHUFFLE);
    busy_d        = (state_d != ST_READY);
  end

  // State and registered outputs; reset drops any in-flight card.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_SHUFFLE;
      ptr_q         <= 6'd0;
      left_q        <= DECK_SIZE_W;
      init_cnt_q    <= 3'd0;
      end_pend_q    <= 1'b0;
      in_round_q    <= 1'b0;
      pend_q        <= 1'b0;
      tgt_dealer_q  <= 1'b0;
      tgt_init_q    <= 1'b0;
      shuffle_req_q <= 1'b0;
      card_valid_q  <= 1'b0;
      hit_ack_q     <= 1'b0;
      dealer_ack_q  <= 1'b0;
      to_dealer_q   <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      left_q        <= left_d;
      init_cnt_q    <= init_cnt_d;
      end_pend_q    <= end_pend_d;
      in_round_q    <= in_round_d;
      pend_q        <= pend_d;
      tgt_dealer_q  <= tgt_dealer_d;
      tgt_init_q    <= tgt_init_d;
      shuffle_req_q <= shuffle_req_d;
      card_valid_q  <= card_valid_d;
      hit_ack_q     <= hit_ack_d;
      dealer_ack_q  <= dealer_ack_d;
      to_dealer_q   <= to_dealer_d;
      busy_q        <= busy_d;
    end
  end

  // The deck RAM answers one cycle after the index, so the card itself is
  // forwarded during ISSUE and gated to zero outside the valid pulse.
  always_comb begin
    if (card_valid_q) begin
      card_out_o   = deck_card_i;
      card_value_o = lut_value_s;
    end else begin
      card_out_o   = 6'd0;
      card_value_o = 4'd0;
    end
  end

  assign shuffle_req_o    = shuffle_req_q;
  assign deck_idx_o       = ptr_q;
  assign hit_ack_o        = hit_ack_q;
  assign dealer_ack_o     = dealer_ack_q;
  assign card_valid_o     = card_valid_q;
  assign card_to_dealer_o = to_dealer_q;
  assign cards_left_o     = left_q;
  assign busy_o           = busy_q;

endmodule
